// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibble index width; a single-nibble build still needs one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between the lab top level and the serial adder.
// Latency: n/a (wires only).
// Backpressure: busy tells the requester that start is currently ignored.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, cin, a, b, input busy, done, sum, cout);
  modport slave  (input start, cin, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Combinational 4-bit adder with carry-in, reused once per nibble.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module nibble_adder_cin
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  // Widen to 5 bits so bit 4 carries the nibble carry-out.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a shared 4-bit adder.
// Latency: done rises NIBBLES+1 cycles after the start cycle; one add per NIBBLES+2 cycles.
// Backpressure: start is only sampled in IDLE; busy is high while it would be ignored.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);

  localparam int                 NIBBLES  = WIDTH / NIBBLE_W;
  localparam int                 IDX_W    = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                state_q;
  state_t                state_d;
  logic                  load;
  logic                  step;
  logic [IDX_W-1:0]      idx_q;
  logic                  carry_q;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [WIDTH-1:0]      sum_q;
  logic                  cout_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NIBBLE_W-1:0]   nib_a;
  logic [NIBBLE_W-1:0]   nib_b;
  logic [NIBBLE_W-1:0]   nib_s;
  logic                  nib_co;

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_adder_cin u_adder (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // Next-state decode: accept in IDLE, walk nibbles in RUN, pulse DONE once.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus busy/done flops, loaded from the next state so outputs stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Operand capture on accept; one nibble of sum and the ripple carry per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (load) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.cin;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_s;
      carry_q <= nib_co;
      if (idx_q == LAST_IDX) begin
        cout_q <= nib_co;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for the nibble-serial adder (16-bit and 4-bit builds).
// Latency: expects done NIBBLES+1 cycles after the start cycle.
// Backpressure: exercises start while busy and back-to-back held start.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [16:0] sb16[$];
  logic [4:0]  sb4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    bus16.start = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;
    bus4.start  = 1'b0; bus4.cin  = 1'b0; bus4.a  = '0; bus4.b  = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus16.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy16: got %b want 0", bus16.busy); end
    n_checks++; if (bus16.done !== 1'b0) begin n_fail++; $display("FAIL reset_done16: got %b want 0", bus16.done); end
    n_checks++; if (bus16.sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum16: got %h want 0", bus16.sum); end
    n_checks++; if (bus16.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout16: got %b want 0", bus16.cout); end
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", bus4.busy); end
    n_checks++; if ({bus4.cout, bus4.sum} !== 5'h0) begin n_fail++; $display("FAIL reset_sum4: got %h want 0", {bus4.cout, bus4.sum}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One 16-bit add with a single-cycle start; checks latency, busy span and result.
  task automatic run_add16(input logic [15:0] a, input logic [15:0] b, input logic ci, input string name);
    int          lat = 0;
    int          busy_cnt = 0;
    bit          got = 0;
    logic [16:0] exp;
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = ci; bus16.start = 1'b1;
    sb16.push_back({1'b0, a} + {1'b0, b} + {16'h0, ci});
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus16.start = 1'b0;
      if (bus16.busy) busy_cnt++;
      if (bus16.done) begin lat = k; got = 1; break; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s_timeout: no done within 20 cycles", name); return; end
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL %s_latency: got %0d want 5", name, lat); end
    n_checks++; if (busy_cnt != 5) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 5", name, busy_cnt); end
    exp = sb16.pop_front();
    n_checks++; if ({bus16.cout, bus16.sum} !== exp) begin n_fail++; $display("FAIL %s_result: got %h want %h", name, {bus16.cout, bus16.sum}, exp); end
    @(negedge clk);
    n_checks++; if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin n_fail++; $display("FAIL %s_after_done: done=%b busy=%b want 0 0", name, bus16.done, bus16.busy); end
    n_checks++; if ({bus16.cout, bus16.sum} !== exp) begin n_fail++; $display("FAIL %s_hold: got %h want %h", name, {bus16.cout, bus16.sum}, exp); end
  endtask

  task automatic test_basic();
    run_add16(16'h1234, 16'h4321, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_add16(16'hFFFF, 16'h0001, 1'b0, "wrap_ones");
    run_add16(16'h0000, 16'h0000, 1'b1, "cin_only");
    run_add16(16'h8F7A, 16'h70C9, 1'b1, "mixed");
  endtask

  task automatic test_ignore_start();
    int          dones = 0;
    int          lat = 0;
    logic [16:0] exp;
    @(negedge clk);
    bus16.a = 16'h00FF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.start = 1'b1;
    sb16.push_back({1'b0, 16'h00FF} + {1'b0, 16'h0001});
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin bus16.a = 16'hABCD; bus16.b = 16'h1357; bus16.cin = 1'b1; end
      if (k == 2) bus16.start = 1'b0;
      if (k == 3) bus16.start = 1'b1;
      if (k == 4) bus16.start = 1'b0;
      if (bus16.done) begin
        dones++;
        if (dones == 1) begin
          lat = k;
          exp = sb16.pop_front();
          n_checks++; if ({bus16.cout, bus16.sum} !== exp) begin n_fail++; $display("FAIL ignore_result: got %h want %h", {bus16.cout, bus16.sum}, exp); end
        end
      end
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL ignore_latency: got %0d want 5", lat); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus16.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", bus16.busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: busy=%b done=%b want 0 0", bus16.busy, bus16.done); end
    n_checks++; if ({bus16.cout, bus16.sum} !== 17'h0) begin n_fail++; $display("FAIL abort_result: got %h want 0", {bus16.cout, bus16.sum}); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus16.done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", dones); end
    run_add16(16'h0F0F, 16'h0101, 1'b0, "after_abort");
  endtask

  task automatic test_width4();
    logic [3:0] va[2];
    logic [3:0] vb[2];
    logic       vc[2];
    logic [4:0] exp;
    va[0] = 4'hF; vb[0] = 4'h1; vc[0] = 1'b0;
    va[1] = 4'h7; vb[1] = 4'h5; vc[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      int lat = 0;
      bit got = 0;
      @(negedge clk);
      bus4.a = va[t]; bus4.b = vb[t]; bus4.cin = vc[t]; bus4.start = 1'b1;
      sb4.push_back({1'b0, va[t]} + {1'b0, vb[t]} + {4'h0, vc[t]});
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k == 1) bus4.start = 1'b0;
        if (bus4.done) begin lat = k; got = 1; break; end
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL w4_timeout_%0d: no done within 10 cycles", t); continue; end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL w4_latency_%0d: got %0d want 2", t, lat); end
      exp = sb4.pop_front();
      n_checks++; if ({bus4.cout, bus4.sum} !== exp) begin n_fail++; $display("FAIL w4_result_%0d: got %h want %h", t, {bus4.cout, bus4.sum}, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] exp;
    int          prev_cyc = 0;
    @(negedge clk);
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
    bus16.a = ra; bus16.b = rb; bus16.cin = rc; bus16.start = 1'b1;
    sb16.push_back({1'b0, ra} + {1'b0, rb} + {16'h0, rc});
    for (int i = 0; i < 1000; i++) begin
      bit got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus16.done) begin got = 1; break; end
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL b2b_timeout: op %0d no done within 20 cycles", i); break; end
      exp = sb16.pop_front();
      n_checks++; if ({bus16.cout, bus16.sum} !== exp) begin n_fail++; $display("FAIL b2b_result: op %0d got %h want %h", i, {bus16.cout, bus16.sum}, exp); end
      if (i > 0) begin
        n_checks++; if (cyc - prev_cyc != 6) begin n_fail++; $display("FAIL b2b_spacing: op %0d got %0d cycles want 6", i, cyc - prev_cyc); end
      end
      prev_cyc = cyc;
      if (i < 999) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
        bus16.a = ra; bus16.b = rb; bus16.cin = rc;
        sb16.push_back({1'b0, ra} + {1'b0, rb} + {16'h0, rc});
      end else begin
        bus16.start = 1'b0;
      end
    end
    bus16.start = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (sb16.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d results outstanding want 0", sb16.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_reset_abort();
    test_width4();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
